// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver: oversampled majority-vote bit recovery,
// optional parity, one or two stop bits, and error/break/end-of-packet reporting.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int IDLE_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_idle,
  output logic                 rx_eop
);

  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int GW  = $clog2(IDLE_BITS * OVERSAMPLE + 1);
  localparam logic [SW-1:0] S_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_VOTEA = SW'(MID - 1);
  localparam logic [SW-1:0] S_VOTEB = SW'(MID);
  localparam logic [SW-1:0] S_VOTEC = SW'(MID + 1);
  localparam logic [GW-1:0] GAP_SAT = GW'(IDLE_BITS * OVERSAMPLE);
  localparam logic [GW-1:0] G_ONE   = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] G_ZERO  = {GW{1'b0}};
  localparam logic [DIV_WIDTH-1:0] D_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] D_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic evenParity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  state_t               state, stateNext;
  logic                 rxdMeta, rxdSync;
  logic [DIV_WIDTH-1:0] divShadow, tickCnt;
  logic [1:0]           parShadow;
  logic                 stop2Shadow;
  logic [SW-1:0]        sCnt, pos;
  logic                 sampA, sampB, vote;
  logic                 tick, atVote, atWrap, parEn, lastStop, issue;
  logic [3:0]           bitCnt;
  logic                 stopIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parErrR, frameErrR, allZeroR;
  logic [GW-1:0]        gapCnt, gapNext;

  // Next-state decode; pos is the sample position the current tick lands on.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    tick      = (tickCnt == D_ZERO);
    if (sCnt == S_LAST) pos = S_ZERO;
    else                pos = sCnt + S_ONE;
    parEn    = (parShadow == 2'b01) || (parShadow == 2'b10);
    vote     = maj3(sampA, sampB, rxdSync);
    atVote   = tick && (pos == S_VOTEC);
    atWrap   = tick && (pos == S_ZERO);
    lastStop = stopIdx || !stop2Shadow;
    if (state != IDLE)                       gapNext = G_ZERO;
    else if (tick && (gapCnt != GAP_SAT))    gapNext = gapCnt + G_ONE;
    else                                     gapNext = gapCnt;
    case (state)
      IDLE:     if (tick && !rxdSync) stateNext = START; else stateNext = IDLE;
      START:    if (atVote && vote) stateNext = IDLE;
                else if (atWrap)    stateNext = DATA;
                else                stateNext = START;
      DATA:     if (atWrap && (bitCnt == BIT_LAST)) stateNext = parEn ? PARITY : STOP;
                else                                stateNext = DATA;
      PARITY:   if (atWrap) stateNext = STOP; else stateNext = PARITY;
      STOP: begin
        if (atVote && lastStop) begin
          issue     = 1'b1;
          stateNext = (allZeroR && !vote) ? BRK_WAIT : IDLE;
        end else begin
          stateNext = STOP;
        end
      end
      BRK_WAIT: if (tick && rxdSync) stateNext = IDLE; else stateNext = BRK_WAIT;
      default:  stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Synchroniser, tick divider and configuration shadowing (tracks inputs only while idle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxdMeta     <= 1'b1;
      rxdSync     <= 1'b1;
      tickCnt     <= D_ZERO;
      divShadow   <= D_ZERO;
      parShadow   <= 2'b00;
      stop2Shadow <= 1'b0;
    end else begin
      rxdMeta <= rxd;
      rxdSync <= rxdMeta;
      if (tick) tickCnt <= divShadow;
      else      tickCnt <= tickCnt - D_ONE;
      if (state == IDLE) begin
        divShadow   <= baud_div;
        parShadow   <= parity_mode;
        stop2Shadow <= stop2;
      end
    end
  end

  // Frame datapath: sampling, shifting and error accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE)) begin
      sCnt      <= S_ZERO;
      bitCnt    <= 4'd0;
      stopIdx   <= 1'b0;
      sampA     <= 1'b1;
      sampB     <= 1'b1;
      parErrR   <= 1'b0;
      frameErrR <= 1'b0;
      allZeroR  <= 1'b1;
      if (!rst_n) shiftReg <= {DATA_BITS{1'b0}};
    end else if (tick) begin
      sCnt <= pos;
      if (pos == S_VOTEA) sampA <= rxdSync;
      if (pos == S_VOTEB) sampB <= rxdSync;
      if (pos == S_VOTEC) begin
        case (state)
          DATA: begin
            shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
            allZeroR <= allZeroR & !vote;
          end
          PARITY: begin
            parErrR  <= vote != (evenParity(shiftReg) ^ (parShadow == 2'b10));
            allZeroR <= allZeroR & !vote;
          end
          STOP: begin
            frameErrR <= frameErrR | !vote;
            allZeroR  <= allZeroR & !vote;
          end
          default: ;
        endcase
      end
      if (pos == S_ZERO) begin
        case (state)
          DATA:    bitCnt  <= bitCnt + 4'd1;
          STOP:    stopIdx <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs and idle-gap tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gapCnt     <= GAP_SAT;
      rx_idle    <= 1'b1;
      rx_eop     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= {DATA_BITS{1'b0}};
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      gapCnt   <= gapNext;
      rx_idle  <= (gapNext == GAP_SAT);
      rx_eop   <= (gapNext == GAP_SAT) && (gapCnt != GAP_SAT);
      rx_valid <= issue;
      if (issue) begin
        rx_data    <= shiftReg;
        parity_err <= parErrR;
        frame_err  <= frameErrR | !vote;
        break_det  <= allZeroR & !vote;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised RS-232 asynchronous receiver, the next generation of the fixed 8N1 receiver in the serial I/O library. It supports configurable data width, runtime baud divisor, optional parity, 1 or 2 stop bits, majority-vote sampling, and error, break and end-of-packet reporting. It sits between the synchronised board RxD pin and the byte-stream consumers, such as the command parser and the packet FIFO.

## Interface
- DATA_BITS, 8: data bits per character, legal 5..9.
- OVERSAMPLE, 16: ticks per bit, even, legal 8..32.
- DIV_WIDTH, 16: width of baud_div.
- IDLE_BITS, 2: gap length, in bit times, that ends a packet.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- baud_div  in  DIV_WIDTH  clocks per oversample tick minus 1.
- parity_mode  in  2  00/11 none, 01 even, 10 odd.
- stop2  in  1  1 = two stop bits expected.
- rxd  in  1  serial line, idle high, asynchronous.
- rx_data  out  DATA_BITS  received character, LSB = first bit on the wire.
- rx_valid  out  1  one-clk pulse; rx_data and the error flags are valid.
- parity_err  out  1  qualified by rx_valid.
- frame_err  out  1  qualified by rx_valid; a stop bit was sampled 0.
- break_det  out  1  qualified by rx_valid; line held low for a whole frame.
- rx_idle  out  1  level; no frame for IDLE_BITS bit times.
- rx_eop  out  1  one-clk pulse when rx_idle rises.

## Operation
- **Input synchroniser.** rxd passes through a 2-FF synchroniser; both flops reset to 1.
- **Tick generator.**
  - A down-counter reloads from the shadow baud_div.
  - A tick is asserted for one clk when the counter equals 0; the counter resets to 0.
- **Shadow configuration.** baud_div, parity_mode and stop2 are copied into shadow registers every clk while in IDLE, and frozen otherwise.
- **Bit position.** A sample counter s runs 0..OVERSAMPLE-1 per bit and advances on ticks.
- **Majority vote.**
  - At s = M-1, M and M+1, with M = OVERSAMPLE/2, the synced bit is sampled.
  - The bit value is the majority of the 3 samples, decided at s = M+1.
- **States:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: on a tick with synced rxd = 0, go to START with s = 0.
  - START: if the vote = 1, return to IDLE (false start, no output). Otherwise go to DATA at s wrap.
  - DATA: shift in DATA_BITS votes, LSB first. Go to PARITY if parity is enabled, else to STOP.
  - PARITY:
    - Expected even parity = XOR of the data bits; expected odd parity = its inverse.
    - On a mismatch, set the internal parity-error bit.
  - STOP:
    - Stop bit 1 is voted. With stop2, stop bit 2 follows after a full bit.
    - At the vote of the last stop bit, the outputs are issued.
    - Go to IDLE, or to BRK_WAIT if a break was detected. There is no wait for the bit end, so the receiver resyncs on the next start edge.
  - BRK_WAIT: on the first tick with synced rxd = 1, go to IDLE.
- **Error flags.**
  - frame_err = any stop vote was 0.
  - break_det = all data, parity and stop votes were 0. break_det implies frame_err.
  - rx_valid is asserted even when an error flag is set.
- **Idle and end of packet.**
  - A gap counter clears whenever the state is not IDLE, and counts ticks in IDLE.
  - It saturates at IDLE_BITS*OVERSAMPLE; rx_idle = saturated.
  - rx_eop pulses on the clk where the counter reaches saturation.
  - The counter resets to the saturated value, so no eop is issued after reset.
- **Reset.**
  - Outputs: rx_data = 0, rx_valid = parity_err = frame_err = break_det = rx_eop = 0, rx_idle = 1.
  - State: IDLE.
  - Reset mid-frame aborts the frame silently.

## Timing
- Tick period is baud_div+1 clks; bit time is OVERSAMPLE*(baud_div+1) clks.
- rx_valid and the flags register 1 clk after the tick deciding the last stop vote. They hold until the next rx_valid, except rx_valid itself, which is a single-clk pulse.
- Start-edge-to-rx_valid latency:
  - Synchroniser: 2 clks.
  - Detect: up to 1 tick.
  - Frame: ((1+DATA_BITS+P+S-1)*OVERSAMPLE + M+1) ticks, where P = 1 if parity is enabled and S = 1 or 2 stop bits.
  - Output register: 1 clk.
- A new start edge is accepted from the tick after return to IDLE. Back-to-back frames with no inter-character gap must be received.
- The shortest legal baud_div is 0 (tick every clk).

## Test plan
All scenarios use DATA_BITS=8, OVERSAMPLE=16, baud_div=3 (64 clks per bit).
- **8N1 character.** Send 0xA5 -> exactly one rx_valid, rx_data=0xA5, all flags 0. Latency is within ±1 tick of 2+1+(9*16+9)*4+1 clks.
- **Parity.** With parity_mode=01, send 0x37 with parity bit 0 -> parity_err=1. Resend with parity bit 1 -> parity_err=0. With parity_mode=10, expect the inverse result.
- **Framing, break and stop2.**
  - Send 0x55 with stop bit 0, then line high -> frame_err=1, break_det=0.
  - Hold the line low for 20 bit times -> a single rx_valid with rx_data=0x00, frame_err=1, break_det=1. No further rx_valid until the line goes high and a new frame is sent.
  - With stop2=1, a second stop bit of 0 -> frame_err=1.
- **Noise and false start.**
  - A 4-clk low glitch on an idle line -> no rx_valid; the FSM returns to IDLE.
  - Invert one tick at s=M inside data bit 3 of 0x0F -> rx_data=0x0F.
- **Packet boundary and reset.**
  - Send 0x11 and 0x22 back to back, then idle -> two rx_valid pulses, then a single rx_eop 2*16 ticks after the last frame returns to IDLE.
  - Assert rst_n=0 mid-frame -> no rx_valid, outputs at reset values, rx_idle=1.
